// File: rtl/req_dir_seq.sv
// Request/direction sequencer: deframes receiver bytes, recognises a marker-headed
// frame, and runs timed set/clear sequences on the direction and address-enable lines.
module req_dir_seq #(
  parameter int DATA_W    = 8,
  parameter int MARKER    = 66,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 12,
  parameter int T_RX      = 1000,
  parameter int T_TX      = 500,
  parameter int T_ADDR    = 500,
  parameter int T_CLR_TX  = 1000,
  parameter int T_CLR_RX  = 500,
  parameter int T_BYTE_TO = 4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] from_mfk,
  input  logic              rx_valid,
  input  logic              rstClr,
  output logic              dir_RX,
  output logic              dir_TX,
  output logic              addr_ena,
  output logic              frame_ok,
  output logic              frame_err,
  output logic              drop,
  output logic              busy
);

  // state  | meaning
  // R_HUNT | waiting for a marker byte
  // R_COLL | collecting frame bytes, inter-byte timeout armed
  // S_IDLE | sequencer waiting for a frame
  // S_RX   | RX window before dir_RX rises
  // S_TX   | delay before dir_TX and addr_ena rise
  // S_ADDR | addr_ena window
  // C_TX   | clear delay before dir_TX falls
  // C_RX   | clear delay before dir_RX falls
  typedef enum logic {R_HUNT, R_COLL} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_RX, S_TX, S_ADDR, C_TX, C_RX} seq_state_t;

  localparam logic [DATA_W-1:0] MARK     = DATA_W'(MARKER);
  localparam logic [3:0]        IDX_LAST = 4'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  RX_LAST  = CNT_W'(T_RX - 1);
  localparam logic [CNT_W-1:0]  TX_LAST  = CNT_W'(T_TX - 1);
  localparam logic [CNT_W-1:0]  AD_LAST  = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0]  CTX_LAST = CNT_W'(T_CLR_TX - 1);
  localparam logic [CNT_W-1:0]  CRX_LAST = CNT_W'(T_CLR_RX - 1);
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(T_BYTE_TO - 1);
  localparam bit                TO_EN    = (T_BYTE_TO != 0);

  rx_state_t        rx_st;
  seq_state_t       seq_st;
  logic             rx_valid_q, rst_clr_q;
  logic             strb, clr_edge;
  logic [3:0]       idx;
  logic [CNT_W-1:0] to_cnt, ph_cnt;

  assign strb     = rx_valid_q & ~rx_valid;
  assign clr_edge = rst_clr_q & ~rstClr;
  assign busy     = (seq_st != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      rx_st      <= R_HUNT;
      idx        <= '0;
      to_cnt     <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_st == R_HUNT) begin
        to_cnt <= '0;
        if (strb && from_mfk == MARK) begin
          rx_st <= R_COLL;
          idx   <= 4'd1;
        end
      end else if (strb) begin
        // a marker byte while collecting is plain data
        to_cnt <= '0;
        if (idx == IDX_LAST) begin
          frame_ok <= 1'b1;
          rx_st    <= R_HUNT;
          idx      <= '0;
        end else begin
          idx <= idx + 4'd1;
        end
      end else if (TO_EN && to_cnt == TO_LAST) begin
        frame_err <= 1'b1;
        rx_st     <= R_HUNT;
        idx       <= '0;
        to_cnt    <= '0;
      end else begin
        to_cnt <= to_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rst_clr_q <= 1'b0;
      seq_st    <= S_IDLE;
      ph_cnt    <= '0;
      dir_RX    <= 1'b0;
      dir_TX    <= 1'b0;
      addr_ena  <= 1'b0;
      drop      <= 1'b0;
    end else begin
      rst_clr_q <= rstClr;
      drop      <= frame_ok && (seq_st != S_IDLE || clr_edge);
      if (clr_edge) begin
        // clear aborts anything in flight; direction lines are left as they are
        seq_st   <= C_TX;
        ph_cnt   <= '0;
        addr_ena <= 1'b0;
      end else begin
        case (seq_st)
          S_IDLE: begin
            ph_cnt <= '0;
            if (frame_ok) seq_st <= S_RX;
          end
          S_RX:
            if (ph_cnt == RX_LAST) begin
              seq_st <= S_TX;
              ph_cnt <= '0;
              dir_RX <= 1'b1;
            end else ph_cnt <= ph_cnt + CNT_W'(1);
          S_TX:
            if (ph_cnt == TX_LAST) begin
              seq_st   <= S_ADDR;
              ph_cnt   <= '0;
              dir_TX   <= 1'b1;
              addr_ena <= 1'b1;
            end else ph_cnt <= ph_cnt + CNT_W'(1);
          S_ADDR:
            if (ph_cnt == AD_LAST) begin
              seq_st   <= S_IDLE;
              ph_cnt   <= '0;
              addr_ena <= 1'b0;
            end else ph_cnt <= ph_cnt + CNT_W'(1);
          C_TX:
            if (ph_cnt == CTX_LAST) begin
              seq_st <= C_RX;
              ph_cnt <= '0;
              dir_TX <= 1'b0;
            end else ph_cnt <= ph_cnt + CNT_W'(1);
          C_RX:
            if (ph_cnt == CRX_LAST) begin
              seq_st <= S_IDLE;
              ph_cnt <= '0;
              dir_RX <= 1'b0;
            end else ph_cnt <= ph_cnt + CNT_W'(1);
          default: begin
            seq_st <= S_IDLE;
            ph_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_req_dir_seq.sv
// Directed-plus-random bench for req_dir_seq; expected event cycles are computed
// from the frame rules and phase durations with plain arithmetic.
module tb_req_dir_seq;
  localparam int MARKER = 66, FRAME_LEN = 8;
  localparam int T_RX = 1000, T_TX = 500, T_ADDR = 500;
  localparam int T_CLR_TX = 1000, T_CLR_RX = 500, T_BYTE_TO = 4000;

  logic       clk = 1'b0;
  logic       rst_n, rx_valid, rstClr;
  logic [7:0] from_mfk;
  logic       dir_RX, dir_TX, addr_ena, frame_ok, frame_err, drop, busy;

  req_dir_seq dut (
    .clk(clk), .rst_n(rst_n), .from_mfk(from_mfk), .rx_valid(rx_valid), .rstClr(rstClr),
    .dir_RX(dir_RX), .dir_TX(dir_TX), .addr_ena(addr_ena), .frame_ok(frame_ok),
    .frame_err(frame_err), .drop(drop), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int n_fok = 0, n_ferr = 0, n_drop = 0, n_addr_hi = 0, n_rx_rise = 0;
  int t_fok = -1, t_ferr = -1, t_drop = -1, t_busy_fall = -1;
  int t_rx_rise = -1, t_rx_fall = -1, t_tx_rise = -1, t_tx_fall = -1;
  int t_addr_rise = -1, t_addr_fall = -1;
  logic p_rx = 0, p_tx = 0, p_addr = 0, p_busy = 0;

  always @(negedge clk) begin
    if (frame_ok)  begin n_fok++;  t_fok  = cyc; end
    if (frame_err) begin n_ferr++; t_ferr = cyc; end
    if (drop)      begin n_drop++; t_drop = cyc; end
    if (addr_ena)  n_addr_hi++;
    if (dir_RX && !p_rx) begin n_rx_rise++; t_rx_rise = cyc; end
    if (!dir_RX && p_rx) t_rx_fall = cyc;
    if (dir_TX && !p_tx) t_tx_rise = cyc;
    if (!dir_TX && p_tx) t_tx_fall = cyc;
    if (addr_ena && !p_addr) t_addr_rise = cyc;
    if (!addr_ena && p_addr) t_addr_fall = cyc;
    if (!busy && p_busy) t_busy_fall = cyc;
    p_rx = dir_RX; p_tx = dir_TX; p_addr = addr_ena; p_busy = busy;
  end

  int bytes[$];
  int strb_cyc[$];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_cycle(input int n);
    while (cyc < n) step();
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Send the queued bytes; strobe cycle of each byte is logged. With tail=0 the
  // task returns in the strobe cycle of the last byte.
  task automatic send_bytes(input bit tail);
    strb_cyc.delete();
    foreach (bytes[i]) begin
      from_mfk = 8'(bytes[i]);
      rx_valid = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      rx_valid = 1'b0;
      strb_cyc.push_back(cyc);
      if (tail || i != bytes.size() - 1) repeat ($urandom_range(1, 3)) step();
    end
  endtask

  function automatic int rand_data();
    return $urandom_range(0, 255);
  endfunction

  function automatic int rand_non_marker();
    int v = $urandom_range(0, 254);
    return (v >= MARKER) ? v + 1 : v;
  endfunction

  // Frame ends FRAME_LEN-1 bytes after the first marker; -1 if incomplete.
  function automatic int frame_end(input int b[$]);
    foreach (b[i])
      if (b[i] == MARKER) return (i + FRAME_LEN - 1 < b.size()) ? i + FRAME_LEN - 1 : -1;
    return -1;
  endfunction

  task automatic rand_frame();
    bytes.delete();
    bytes.push_back(MARKER);
    for (int i = 1; i < FRAME_LEN; i++) bytes.push_back(rand_data());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle %0d expected finish before", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k, k2, c, t, r, e, s0_fok, s0_ferr, s0_drop, s0_ahi, s0_rxr;
    rst_n = 1'b0; rx_valid = 1'b0; rstClr = 1'b0; from_mfk = '0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_dir_rx", dir_RX, 0);
    chk("rst_dir_tx", dir_TX, 0);
    chk("rst_addr", addr_ena, 0);
    chk("rst_pulses", {frame_ok, frame_err, drop}, 0);
    chk("rst_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();

    // Full set sequence from 66,1..7
    bytes = {MARKER, 1, 2, 3, 4, 5, 6, 7};
    s0_fok = n_fok; s0_ahi = n_addr_hi;
    send_bytes(1'b1);
    k = strb_cyc[FRAME_LEN-1] + 1;
    at_cycle(k + T_RX + T_TX + T_ADDR + 5);
    chk("a_fok_n", n_fok - s0_fok, 1);
    chk("a_fok_t", t_fok, k);
    chk("a_rx_rise", t_rx_rise, k + T_RX + 1);
    chk("a_tx_rise", t_tx_rise, k + T_RX + T_TX + 1);
    chk("a_addr_rise", t_addr_rise, k + T_RX + T_TX + 1);
    chk("a_addr_len", n_addr_hi - s0_ahi, T_ADDR);
    chk("a_addr_fall", t_addr_fall, k + T_RX + T_TX + T_ADDR + 1);
    chk("a_busy_fall", t_busy_fall, k + T_RX + T_TX + T_ADDR + 1);
    chk("a_dirs_held", {dir_RX, dir_TX}, 3);

    // Clear after completed sequence
    rstClr = 1'b1; step(); step();
    rstClr = 1'b0; c = cyc;
    at_cycle(c + T_CLR_TX + T_CLR_RX + 5);
    chk("b_tx_fall", t_tx_fall, c + T_CLR_TX + 1);
    chk("b_rx_fall", t_rx_fall, c + T_CLR_TX + T_CLR_RX + 1);
    chk("b_busy_fall", t_busy_fall, c + T_CLR_TX + T_CLR_RX + 1);

    // Leading junk, marker-valued data byte, then clear at cycle 200 of S_ADDR
    bytes.delete();
    repeat ($urandom_range(2, 4)) bytes.push_back(rand_non_marker());
    bytes.push_back(MARKER);
    for (int i = 1; i < FRAME_LEN; i++) bytes.push_back(i == 3 ? MARKER : rand_data());
    e = frame_end(bytes);
    s0_fok = n_fok; s0_ahi = n_addr_hi;
    send_bytes(1'b1);
    k = strb_cyc[e] + 1;
    c = k + T_RX + T_TX + 200;
    at_cycle(c - 1);
    rstClr = 1'b1; step();
    rstClr = 1'b0;
    at_cycle(c + T_CLR_TX + T_CLR_RX + 5);
    chk("c_fok_n", n_fok - s0_fok, 1);
    chk("c_fok_t", t_fok, k);
    chk("c_addr_fall", t_addr_fall, c + 1);
    chk("c_addr_len", n_addr_hi - s0_ahi, 200);
    chk("c_tx_fall", t_tx_fall, c + T_CLR_TX + 1);
    chk("c_rx_fall", t_rx_fall, c + T_CLR_TX + T_CLR_RX + 1);
    chk("c_busy_fall", t_busy_fall, c + T_CLR_TX + T_CLR_RX + 1);

    // Truncated frame: inter-byte timeout
    bytes = {MARKER, rand_data(), rand_data(), rand_data()};
    s0_fok = n_fok; s0_ferr = n_ferr;
    send_bytes(1'b1);
    t = strb_cyc[3];
    at_cycle(t + T_BYTE_TO + 5);
    chk("d_ferr_n", n_ferr - s0_ferr, 1);
    chk("d_ferr_t", t_ferr, t + T_BYTE_TO + 1);
    chk("d_fok_n", n_fok - s0_fok, 0);
    chk("d_busy", busy, 0);

    // Next frame accepted; second frame during S_TX is dropped
    rand_frame();
    s0_fok = n_fok; s0_drop = n_drop; s0_ahi = n_addr_hi;
    send_bytes(1'b1);
    k = strb_cyc[FRAME_LEN-1] + 1;
    at_cycle(k + T_RX + 5);
    rand_frame();
    send_bytes(1'b1);
    k2 = strb_cyc[FRAME_LEN-1] + 1;
    at_cycle(k + T_RX + T_TX + T_ADDR + 5);
    chk("e_fok_t1", k2 < k + T_RX + T_TX ? 1 : 0, 1);
    chk("e_fok_n", n_fok - s0_fok, 2);
    chk("e_drop_n", n_drop - s0_drop, 1);
    chk("e_drop_t", t_drop, k2 + 1);
    chk("e_tx_rise", t_tx_rise, k + T_RX + T_TX + 1);
    chk("e_addr_len", n_addr_hi - s0_ahi, T_ADDR);
    chk("e_busy_fall", t_busy_fall, k + T_RX + T_TX + T_ADDR + 1);

    // Reset in the middle of S_RX
    rand_frame();
    send_bytes(1'b1);
    k = strb_cyc[FRAME_LEN-1] + 1;
    s0_rxr = n_rx_rise;
    at_cycle(k + 100);
    rst_n = 1'b0;
    r = cyc;
    step();
    @(negedge clk);
    chk("f_dirs", {dir_RX, dir_TX}, 0);
    chk("f_outs", {addr_ena, frame_ok, frame_err, drop}, 0);
    chk("f_busy", busy, 0);
    rst_n = 1'b1;
    at_cycle(r + T_RX + T_TX + T_ADDR + 100);
    chk("f_no_resume", n_rx_rise - s0_rxr, 0);
    chk("f_idle", busy, 0);

    // Clear edge coincident with frame_ok while idle: clear wins
    rstClr = 1'b1;
    rand_frame();
    s0_fok = n_fok; s0_drop = n_drop; s0_rxr = n_rx_rise;
    step();
    send_bytes(1'b0);
    step();
    rstClr = 1'b0;
    c = cyc;
    at_cycle(c + T_CLR_TX + T_CLR_RX + 5);
    chk("g_fok_t", t_fok, c);
    chk("g_drop_n", n_drop - s0_drop, 1);
    chk("g_drop_t", t_drop, c + 1);
    chk("g_no_set", n_rx_rise - s0_rxr, 0);
    chk("g_busy_fall", t_busy_fall, c + T_CLR_TX + T_CLR_RX + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/req_dir_seq.md
# req_dir_seq

Parametrised successor to the MFK request/direction sequencer. It deframes bytes from the MFK receiver, recognises a marker-headed request frame of configurable length, and runs a timed set sequence: RX window, then `dir_RX`, then `dir_TX`, then an `addr_ena` window. A falling edge on `rstClr` runs a timed clear sequence. Compared with the previous generation it adds a synchronous reset, parametrised widths, marker and phase durations, an inter-byte timeout, clear-aborts-set priority, and status pulses.

## Interface
Parameters:
- `DATA_W`, 8: width of `from_mfk`.
- `MARKER`, 66: frame header byte value.
- `FRAME_LEN`, 8: total frame bytes, marker included. Range 2..15.
- `CNT_W`, 12: phase/timeout counter width. Must hold every `T_*` value.
- `T_RX`, 1000: cycles in the RX window before `dir_RX` rises. Minimum 1.
- `T_TX`, 500: cycles between `dir_RX` rise and `dir_TX` rise. Minimum 1.
- `T_ADDR`, 500: cycles `addr_ena` is held high. Minimum 1.
- `T_CLR_TX`, 1000: cycles from clear edge to `dir_TX` fall. Minimum 1.
- `T_CLR_RX`, 500: cycles from `dir_TX` fall to `dir_RX` fall. Minimum 1.
- `T_BYTE_TO`, 4000: inter-byte timeout while collecting. 0 disables it.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, **synchronous, active-low**.
- `from_mfk` in `DATA_W`: received byte. Valid when the strobe fires.
- `rx_valid` in 1: byte valid from the receiver. Its falling edge is the byte strobe.
- `rstClr` in 1: clear request. Its falling edge starts the clear sequence.
- `dir_RX` out 1: receiver direction, level.
- `dir_TX` out 1: transmitter direction, level.
- `addr_ena` out 1: address enable window.
- `frame_ok` out 1: 1-cycle pulse when a complete frame is recognised.
- `frame_err` out 1: 1-cycle pulse when the inter-byte timeout aborts a frame.
- `drop` out 1: 1-cycle pulse when `frame_ok` arrives while a sequence is running.
- `busy` out 1: high whenever the sequencer is not in `S_IDLE`.

## Operation
Reset (`rst_n`=0 at a clock edge):
- All outputs are 0.
- Edge-detect history registers are 0. A line already high after reset therefore produces no edge until it has been sampled high.
- Both FSMs return to their idle states; counters are 0.

Byte strobe:
- `strb` fires in the cycle where `rx_valid`=0 and the registered previous `rx_valid`=1.
- `from_mfk` is sampled in that same cycle.

Receive FSM:
- `R_HUNT`: a strobe with byte==`MARKER` moves to `R_COLL` with `idx`=1. Any other byte is ignored.
- `R_COLL`: each strobe increments `idx`. A `MARKER` byte here is treated as data; there is no resync.
  - When the strobe brings `idx` to `FRAME_LEN`: pulse `frame_ok` in the next cycle and return to `R_HUNT`.
  - The timeout counter clears on every strobe. If it reaches `T_BYTE_TO` with no strobe (and `T_BYTE_TO`≠0): pulse `frame_err` and return to `R_HUNT`.

Sequencer FSM, states `S_IDLE`, `S_RX`, `S_TX`, `S_ADDR`, `C_TX`, `C_RX`:
- `S_IDLE` + `frame_ok` → `S_RX`.
- `S_RX` runs `T_RX` cycles → `S_TX`; `dir_RX` is set to 1 on this transition.
- `S_TX` runs `T_TX` cycles → `S_ADDR`; `dir_TX` is set to 1 on this transition.
- `S_ADDR` holds `addr_ena`=1 for `T_ADDR` cycles, then → `S_IDLE`.
- Clear edge (`rstClr`=0, previous=1) in any state → `C_TX`.
  - This aborts the set sequence: `addr_ena` is 0 from the next cycle, and the phase counter restarts.
  - `dir_RX`/`dir_TX` keep their current values until the clear sequence changes them.
- `C_TX` runs `T_CLR_TX` cycles → `C_RX`; `dir_TX` is set to 0.
- `C_RX` runs `T_CLR_RX` cycles → `S_IDLE`; `dir_RX` is set to 0.
- A clear edge during `C_TX`/`C_RX` restarts `C_TX` from count 0.
- `frame_ok` in any non-idle state is discarded and pulses `drop`. The receive FSM keeps running regardless of sequencer state.
- Simultaneous clear edge and `frame_ok` in `S_IDLE`: clear wins, and `drop` pulses.

## Timing
- Strobe in cycle s → `frame_ok` high in cycle s+1.
- `frame_ok` in cycle k:
  - `S_RX` covers cycles k+1..k+`T_RX`.
  - `dir_RX`=1 from k+`T_RX`+1.
  - `dir_TX`=1 and `addr_ena`=1 from k+`T_RX`+`T_TX`+1.
  - `addr_ena` is last high at k+`T_RX`+`T_TX`+`T_ADDR`.
  - `busy` falls the cycle after that.
- Clear edge detected in cycle c:
  - `dir_TX`=0 from c+`T_CLR_TX`+1.
  - `dir_RX`=0 from c+`T_CLR_TX`+`T_CLR_RX`+1.
- Timeout: the last strobe in cycle t with no further strobe gives a `frame_err` pulse in cycle t+`T_BYTE_TO`+1.
- Phase counters are `CNT_W` bits, compare for equality with `T_*`−1, and never wrap in normal use.
- `rst_n` low mid-sequence forces all outputs to 0 at that edge.

## Test plan
- Bytes 66,1..7 with defaults → `frame_ok` 1 cycle after the 8th strobe.
  - `dir_RX` rises 1000 cycles later.
  - `dir_TX` and `addr_ena` rise 500 cycles after that.
  - `addr_ena` stays high for exactly 500 cycles.
  - `busy` then falls.
- Bytes 5,9,66,… (8 bytes from the 66) → the leading non-marker bytes are ignored; one `frame_ok` only, after the 8th byte counted from the 66.
- 66 followed by 3 bytes, then silence → `frame_err` exactly 4001 cycles after the last strobe; no `frame_ok`; next frame accepted normally.
- After a full set sequence, pulse `rstClr` 1→0 → `dir_TX` falls after 1000 cycles, `dir_RX` falls 500 cycles later; `busy` ends.
- Clear edge at cycle 200 of `S_ADDR` → `addr_ena` 0 next cycle; `dir_TX` falls 1000 cycles later, then `dir_RX` 500 cycles after that.
- Second frame during `S_TX` → `drop` pulse, no timing change; `rst_n`=0 mid-`S_RX` → all outputs 0, FSMs idle.
